// File: rtl/cwt_pkg.sv
// -----------------------------------------------------------------------------
// cwt_pkg
// Shared types and width helpers for the CWT accumulator slice.
//   state_t        : accumulator FSM states (IDLE, ACC, HOLD)
//   cnt_w_of()     : tap-counter width for a given TAPS
//   acc_w_of()     : accumulator width for a given BITS/TAPS, sized so a full
//                    run of TAPS extreme samples can never wrap
//   sat_hi/sat_lo(): two's-complement bounds of a BITS-wide result
// -----------------------------------------------------------------------------
package cwt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    function automatic int cnt_w_of(input int taps);
        return $clog2(taps);
    endfunction

    function automatic int acc_w_of(input int bits, input int taps);
        return bits + $clog2(taps);
    endfunction

    // Widths for the default configuration (BITS=16, TAPS=32).
    localparam int DEF_CNT_W = cnt_w_of(32);
    localparam int DEF_ACC_W = acc_w_of(16, 32);

    function automatic longint sat_hi(input int bits);
        return (longint'(1) <<< (bits - 1)) - 64'sd1;
    endfunction

    function automatic longint sat_lo(input int bits);
        return -(longint'(1) <<< (bits - 1));
    endfunction

endpackage

// File: rtl/cwt_sat_shift.sv
// -----------------------------------------------------------------------------
// cwt_sat_shift
// Purely combinational scale-and-saturate stage: arithmetic right shift of the
// wide accumulator sum by SHIFT, then clamp into the signed BITS range.
//   sum  in  ACC_W  signed accumulated value
//   sat  out BITS   shifted, saturated result
//   ovf  out 1      shifted value fell outside the BITS range and was clamped
// -----------------------------------------------------------------------------
module cwt_sat_shift
    import cwt_pkg::*;
#(
    parameter int BITS  = 16,
    parameter int ACC_W = 21,
    parameter int SHIFT = 0
) (
    input  logic signed [ACC_W-1:0] sum,
    output logic        [BITS-1:0]  sat,
    output logic                    ovf
);

    localparam logic signed [ACC_W-1:0] HI = ACC_W'(sat_hi(BITS));
    localparam logic signed [ACC_W-1:0] LO = ACC_W'(sat_lo(BITS));

    logic signed [ACC_W-1:0] shifted;

    assign shifted = sum >>> SHIFT;

    // NOTE: every output gets a default before the if-chain so no path leaves
    // it unassigned -- otherwise synthesis infers a latch.
    always_comb begin
        sat = shifted[BITS-1:0];
        ovf = 1'b0;
        if (shifted > HI) begin
            sat = HI[BITS-1:0];
            ovf = 1'b1;
        end else if (shifted < LO) begin
            sat = LO[BITS-1:0];
            ovf = 1'b1;
        end
    end

endmodule

// File: rtl/cwt_accumulator.sv
// -----------------------------------------------------------------------------
// cwt_accumulator
// Accumulates TAPS signed wavelet-product samples into one CWT coefficient,
// scales it by an arithmetic right shift and saturates it back to BITS.
//   clk        in   rising-edge clock
//   rst        in   asynchronous, active-low reset
//   start      in   single-cycle request to begin a coefficient
//   in_valid   in   in_data valid
//   in_data    in   BITS signed sample
//   in_ready   out  sample accepted this cycle (ACC state)
//   out_valid  out  out_data holds a finished coefficient
//   out_data   out  BITS signed, scaled, saturated coefficient
//   out_ready  in   consumer accepts out_data
//   busy       out  high in ACC or HOLD
//   ovf_flag   out  coefficient was saturated (meaningful while out_valid)
// -----------------------------------------------------------------------------
module cwt_accumulator
    import cwt_pkg::*;
#(
    parameter int BITS  = 16,
    parameter int TAPS  = 32,
    parameter int SHIFT = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            in_valid,
    input  logic [BITS-1:0] in_data,
    output logic            in_ready,
    output logic            out_valid,
    output logic [BITS-1:0] out_data,
    input  logic            out_ready,
    output logic            busy,
    output logic            ovf_flag
);

    localparam int CNT_W = cnt_w_of(TAPS);
    localparam int ACC_W = acc_w_of(BITS, TAPS);

    state_t                  state, state_next;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_next;
    logic        [CNT_W-1:0] cnt;
    logic                    xfer;
    logic                    last_tap;
    logic        [BITS-1:0]  sat_value;
    logic                    sat_ovf;

    assign in_ready = (state == ACC);
    assign busy     = (state != IDLE);
    assign xfer     = in_valid && in_ready;
    assign last_tap = (cnt == CNT_W'(TAPS - 1));
    assign acc_next = acc + {{CNT_W{in_data[BITS-1]}}, in_data};

    // Scale/saturate the sum that includes the tap being accepted, so the
    // result is registered on the same edge as the last transfer.
    cwt_sat_shift #(
        .BITS  (BITS),
        .ACC_W (ACC_W),
        .SHIFT (SHIFT)
    ) u_sat_shift (
        .sum (acc_next),
        .sat (sat_value),
        .ovf (sat_ovf)
    );

    // NOTE: state and datapath registers use non-blocking assignments so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = ACC;
            ACC:     if (xfer && last_tap) state_next = HOLD;
            HOLD:    if (out_ready) state_next = start ? ACC : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // NOTE: everything here is a plain register (no memory), so all of it is
    // cleared by the async reset; a reset mid-run drops the partial sum.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc       <= '0;
            cnt       <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            ovf_flag  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        acc      <= '0;
                        cnt      <= '0;
                        ovf_flag <= 1'b0;
                    end
                end
                ACC: begin
                    if (xfer) begin
                        acc <= acc_next;
                        if (last_tap) begin
                            cnt       <= '0;
                            out_data  <= sat_value;
                            out_valid <= 1'b1;
                            ovf_flag  <= sat_ovf;
                        end else begin
                            cnt <= cnt + CNT_W'(1);
                        end
                    end
                end
                HOLD: begin
                    // A start without out_ready is dropped; with out_ready it
                    // launches the next coefficient with no idle bubble.
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (start) begin
                            acc      <= '0;
                            cnt      <= '0;
                            ovf_flag <= 1'b0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_cwt_accumulator.sv
// -----------------------------------------------------------------------------
// tb_cwt_accumulator
// Two DUTs (TAPS=4, BITS=16) share all inputs: dut0 with SHIFT=0, dut1 with
// SHIFT=2. Expected coefficients come from a plain-arithmetic model of the
// sum/shift/clamp rule and are queued per run; a negedge monitor checks every
// out_valid window against them.
// -----------------------------------------------------------------------------
module tb_cwt_accumulator;

    typedef struct {
        logic [15:0] data;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic [1:0]  in_ready, out_valid, busy, ovf_flag;
    logic [15:0] out_data [2];

    int n_tests = 0;
    int n_fail  = 0;

    exp_t exp_q0[$];
    exp_t exp_q1[$];

    always #5 clk = ~clk;

    cwt_accumulator #(.BITS(16), .TAPS(4), .SHIFT(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready[0]), .out_valid(out_valid[0]),
        .out_data(out_data[0]), .out_ready(out_ready), .busy(busy[0]),
        .ovf_flag(ovf_flag[0])
    );

    cwt_accumulator #(.BITS(16), .TAPS(4), .SHIFT(2)) dut1 (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in_data(in_data), .in_ready(in_ready[1]), .out_valid(out_valid[1]),
        .out_data(out_data[1]), .out_ready(out_ready), .busy(busy[1]),
        .ovf_flag(ovf_flag[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Coefficient = clamp((sum of samples) >>> shift) into signed 16 bits.
    function automatic exp_t model(input int s[4], input int shift);
        exp_t   r;
        longint sum = 0;
        for (int i = 0; i < 4; i++) sum += longint'(s[i]);
        sum = sum >>> shift;
        if (sum > 32767) begin
            r.data = 16'h7FFF; r.ovf = 1'b1;
        end else if (sum < -32768) begin
            r.data = 16'h8000; r.ovf = 1'b1;
        end else begin
            r.data = sum[15:0]; r.ovf = 1'b0;
        end
        return r;
    endfunction

    // Monitor: reset values, coefficient value on each out_valid rise,
    // stability while held, and in_ready/busy during HOLD.
    bit   prev_v [2];
    exp_t held   [2];
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (!rst) begin
                check("rst_out_valid", out_valid[d], 0);
                check("rst_out_data",  out_data[d], 0);
                check("rst_in_ready",  in_ready[d], 0);
                check("rst_busy",      busy[d], 0);
                check("rst_ovf",       ovf_flag[d], 0);
                prev_v[d] = 1'b0;
            end else begin
                if (out_valid[d] && !prev_v[d]) begin
                    if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0)) begin
                        check("spurious_out_valid", out_valid[d], 0);
                    end else begin
                        held[d] = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        check("coef_data", out_data[d], held[d].data);
                        check("coef_ovf",  ovf_flag[d], held[d].ovf);
                    end
                end else if (out_valid[d]) begin
                    check("hold_data_stable", out_data[d], held[d].data);
                    check("hold_ovf_stable",  ovf_flag[d], held[d].ovf);
                end
                if (out_valid[d]) begin
                    check("hold_in_ready", in_ready[d], 0);
                    check("hold_busy",     busy[d], 1);
                end
                prev_v[d] = out_valid[d];
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One coefficient run: optional start, four samples, an optional stall
    // of gap_len cycles after sample index gap_after.
    task automatic do_run(input int s0, input int s1, input int s2, input int s3,
                          input bit do_start, input int gap_after, input int gap_len);
        int s[4];
        s = '{s0, s1, s2, s3};
        exp_q0.push_back(model(s, 0));
        exp_q1.push_back(model(s, 2));
        if (do_start) begin
            start = 1'b1;
            step();
            start = 1'b0;
        end
        check("acc_in_ready0", in_ready[0], 1);
        check("acc_in_ready1", in_ready[1], 1);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(s[i]);
            step();
            in_valid = 1'b0;
            if (i == gap_after) begin
                for (int g = 0; g < gap_len; g++) begin
                    check("stall_in_ready", in_ready[0], 1);
                    check("stall_out_valid", out_valid[0], 0);
                    step();
                end
            end
        end
        check("latency_out_valid0", out_valid[0], 1);
        check("latency_out_valid1", out_valid[1], 1);
    endtask

    // Hold the result wait_cycles with out_ready low (optionally offering an
    // extra sample and a dropped start), then hand it off.
    task automatic finish_hold(input int wait_cycles, input bit extra_valid, input bit with_start);
        in_valid = extra_valid;
        in_data  = 16'h0063;
        for (int w = 0; w < wait_cycles; w++) begin
            start = extra_valid;
            step();
            check("hold_wait_valid", out_valid[0], 1);
        end
        start     = with_start;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        start     = 1'b0;
        check("handoff_out_valid", out_valid[0], 0);
        check("handoff_busy",      busy[0], with_start);
        check("handoff_in_ready",  in_ready[0], with_start);
    endtask

    initial begin
        exp_t e;
        int   pin[4];

        // Pin the model against hand-computed values.
        pin = '{1, 2, 3, 4};
        e = model(pin, 0);         check("model_sum", e.data, 16'd10);
        pin = '{28672, 28672, 28672, 28672};
        e = model(pin, 0);         check("model_pos_sat", {e.ovf, e.data}, 17'h1_7FFF);
        e = model(pin, 2);         check("model_shift2", {e.ovf, e.data}, 17'h0_7000);
        pin = '{-28672, -28672, -28672, -28672};
        e = model(pin, 0);         check("model_neg_sat", {e.ovf, e.data}, 17'h1_8000);

        // Reset with random inputs.
        for (int i = 0; i < 3; i++) begin
            start     = 1'($urandom);
            in_valid  = 1'($urandom);
            in_data   = 16'($urandom);
            out_ready = 1'($urandom);
            step();
        end
        start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        rst = 1'b1;
        step();
        check("post_rst_in_ready", in_ready[0], 0);
        check("post_rst_busy",     busy[0], 0);
        check("post_rst_valid",    out_valid[0], 0);

        // Basic sum.
        do_run(1, 2, 3, 4, 1'b1, -1, 0);
        check("basic_data0", out_data[0], 16'd10);
        check("basic_ovf0",  ovf_flag[0], 0);
        check("basic_data1", out_data[1], 16'd2);
        finish_hold(0, 1'b0, 1'b0);
        check("basic_retain", out_data[0], 16'd10);

        // Saturation.
        do_run(28672, 28672, 28672, 28672, 1'b1, -1, 0);
        check("pos_sat_data0", out_data[0], 16'h7FFF);
        check("pos_sat_ovf0",  ovf_flag[0], 1);
        check("pos_sh2_data1", out_data[1], 16'h7000);
        check("pos_sh2_ovf1",  ovf_flag[1], 0);
        finish_hold(0, 1'b0, 1'b0);
        do_run(-28672, -28672, -28672, -28672, 1'b1, -1, 0);
        check("neg_sat_data0", out_data[0], 16'h8000);
        check("neg_sat_ovf0",  ovf_flag[0], 1);
        check("neg_sh2_data1", out_data[1], 16'h9000);
        finish_hold(0, 1'b0, 1'b0);

        // Handshake stress: stall mid-run, back-pressure with extra traffic.
        do_run(-5, 7, -1, 3, 1'b1, 1, 2);
        check("stress_data0", out_data[0], 16'd4);
        finish_hold(3, 1'b1, 1'b0);

        // Mid-run reset.
        start = 1'b1; step(); start = 1'b0;
        in_valid = 1'b1; in_data = 16'd100; step();
        in_data = 16'd200; step();
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("midrst_busy",     busy[0], 0);
        check("midrst_in_ready", in_ready[0], 0);
        step();
        step();
        rst = 1'b1;
        step();
        check("midrst_idle_busy", busy[0], 0);
        do_run(1, 1, 1, 1, 1'b1, -1, 0);
        check("midrst_data0", out_data[0], 16'd4);

        // Back-to-back: out_ready and start together skip IDLE.
        finish_hold(0, 1'b0, 1'b1);
        do_run(2, 2, 2, 2, 1'b0, -1, 0);
        check("b2b_data0", out_data[0], 16'd8);
        check("b2b_data1", out_data[1], 16'd2);
        finish_hold(1, 1'b0, 1'b0);

        step();
        check("exp_q0_drained", exp_q0.size(), 0);
        check("exp_q1_drained", exp_q1.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
